ncsi_rbt_tx: RTL and testbench
==============================

# ncsi_rbt_tx

Transmit-direction RMII-Based Transport (RBT) framer for the NC-SI sideband. It accepts a byte stream (valid/ready, last-marked) from the NC-SI packet mux and serializes it onto the 2-bit RBT receive pins toward the host management controller. On the wire each frame is preamble, SFD, payload, zero pad, FCS, then a mandatory inter-packet gap. It runs entirely in the RBT 50 MHz reference clock domain; any clock-domain crossing happens upstream in the byte-stream FIFO.

## Interface
- IPG_DIBITS, 48: inter-packet gap length in clocks with crs_dv low (48 = 96 bit times).
- MIN_FRAME_BYTES, 60: minimum payload length before FCS. Shorter frames are zero-padded. A value of 0 disables padding.
- clk  in  1  RBT reference clock (ncsi_clk domain, 50 MHz).
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  payload byte.
- tx_valid  in  1  tx_data is valid; must hold with tx_data stable until accepted.
- tx_last  in  1  qualifies tx_data as the final payload byte of the frame.
- tx_ready  out  1  byte is accepted in this cycle if tx_valid=1. Decoded from registered state only; does not depend on tx_valid.
- ncsi_rxd  out  2  RBT receive dibit; bit 0 carries the earlier bit.
- ncsi_crs_dv  out  1  carrier sense / data valid.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse when a frame is aborted because payload starved.

## Operation
- States: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IPG -> IDLE.
- **IDLE**
  - ncsi_crs_dv=0, ncsi_rxd=0.
  - tx_valid=1 moves the block to PRE.
  - No byte is consumed in IDLE.
- **PRE**
  - 28 clocks of dibit 2'b01 (7 bytes of 0x55, LSB first).
- **SFD**
  - 4 clocks sending 0xD5 as dibits 01, 01, 01, 11.
- **Load points**
  - A load point is the 4th dibit clock of SFD, or the 4th dibit of any DATA byte not marked last.
  - tx_ready=1 only at load points. The accepted byte and its tx_last flag go into the shift register and are sent starting the next clock, LSB dibit first.
  - If tx_ready=1 and tx_valid=0, that is an underrun:
    - underrun pulses.
    - crs_dv drops on the next clock; no FCS is sent.
    - The block goes to IPG.
- **DATA**
  - The byte counter (11 bits, saturating at 2047) increments per byte sent.
  - After the last byte: go to PAD if count < MIN_FRAME_BYTES, else to FCS.
- **PAD**
  - Sends 0x00 bytes until count == MIN_FRAME_BYTES, then goes to FCS.
- **CRC**
  - CRC-32, reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD.
  - Updated per dibit over payload and pad only.
- **FCS**
  - 16 clocks sending the complemented CRC, LSB first. Byte order on the wire is crc[7:0] first.
- **IPG**
  - IPG_DIBITS clocks with crs_dv=0 and rxd=0, then IDLE.
  - tx_ready=0 throughout; a tx_valid held high starts the next frame from IDLE.
- **Simultaneous events**
  - tx_last on a byte whose count is still below the minimum: padding follows, with no extra idle between.
  - The first byte of a frame must be offered by the SFD load point; otherwise it is an underrun with zero payload.

## Timing
- Reset values: ncsi_rxd=0, ncsi_crs_dv=0, tx_ready=0, busy=0, underrun=0, state IDLE, CRC=0xFFFFFFFF, counters 0.
- Reset asserted mid-frame:
  - Outputs go to reset values immediately (async).
  - The in-flight frame is dropped with no FCS.
  - After deassertion the block restarts from IDLE.
- All wire outputs are registered. tx_valid rising in IDLE at cycle N gives crs_dv=1 with the first preamble dibit at N+1.
- The first payload dibit appears 33 clocks after tx_valid is seen in IDLE (32 clocks of preamble plus SFD).
- Payload throughput is one byte per 4 clocks. An N-byte frame (N >= MIN) holds crs_dv high for exactly 32 + 4N + 16 clocks.
- Minimum frame-to-frame spacing: crs_dv low for exactly IPG_DIBITS clocks when the next tx_valid is already pending.
- Underrun timing: crs_dv falls in the clock after the starved load point, and IPG starts counting from that clock.

## Test plan
- **Short frame, padded.** 1-byte frame 0xAB with tx_last, MIN=60 -> crs_dv high for 288 clocks. Payload is 0xAB followed by 59 zero bytes, and the FCS matches the model.
- **CRC check vector.** MIN_FRAME_BYTES=0, frame ASCII "123456789" -> FCS bytes on the wire are 0x26, 0x39, 0xF4, 0xCB.
- **Back-to-back frames.** Two 64-byte frames with tx_valid always high -> crs_dv low for exactly 48 clocks between them. tx_ready pulses exactly 64 times per frame, 4 clocks apart.
- **Underrun.** Deassert tx_valid at the 10th byte's load point -> underrun pulses once and crs_dv drops on the next clock with no FCS. After 48 IPG clocks busy falls and the next frame is transmitted correctly.
- **Async reset mid-FCS.** Assert reset during the FCS state -> rxd, crs_dv, busy and tx_ready go to 0 without a clock edge. After deassertion, a 60-byte frame is sent intact.
- **Preamble and SFD pattern.** Any frame -> the first 32 crs_dv cycles are 28× 2'b01 then 01, 01, 01, 11. tx_ready=0 except on the 32nd clock.

Source files
------------

// File: rtl/ncsi_rbt_tx.sv
// NC-SI RBT transmit framer: serializes a valid/ready byte stream onto the 2-bit
// RBT receive pins as preamble, SFD, payload, zero pad, FCS, then an inter-packet gap.
module ncsi_rbt_tx #(
    parameter int IPG_DIBITS      = 48,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [1:0] ncsi_rxd,
    output logic       ncsi_crs_dv,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IPG} state_t;

    localparam logic [15:0] IPG_LAST  = 16'(IPG_DIBITS - 1);
    localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

    state_t      state_reg, state_next;
    logic [15:0] dcnt_reg, dcnt_next;
    logic [7:0]  sh_reg, sh_next;
    logic        last_reg, last_next;
    logic [10:0] byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
    logic [31:0] crc_reg, crc_next, crc_upd;
    logic [1:0]  rxd_reg, rxd_next;
    logic        crs_dv_reg, crs_dv_next;
    logic        underrun_reg, underrun_next;

    // Reflected CRC-32 advanced by one dibit, bit 0 being the earlier bit on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    assign crc_upd      = crc_dibit(crc_reg, rxd_reg);
    assign byte_cnt_inc = (&byte_cnt_reg) ? byte_cnt_reg : byte_cnt_reg + 11'd1;

    assign tx_ready    = (dcnt_reg == 16'd3) &&
                         ((state_reg == SFD) || ((state_reg == DATA) && !last_reg));
    assign busy        = (state_reg != IDLE);
    assign ncsi_rxd    = rxd_reg;
    assign ncsi_crs_dv = crs_dv_reg;
    assign underrun    = underrun_reg;

    // Next-state logic also computes the wire value for the next clock so that
    // rxd/crs_dv come straight from flops.
    always_comb begin
        state_next    = state_reg;
        dcnt_next     = dcnt_reg + 16'd1;
        sh_next       = {2'b00, sh_reg[7:2]};
        last_next     = last_reg;
        byte_cnt_next = byte_cnt_reg;
        crc_next      = crc_reg;
        rxd_next      = 2'b00;
        crs_dv_next   = 1'b0;
        underrun_next = 1'b0;

        case (state_reg)
            IDLE: begin
                dcnt_next = '0;
                if (tx_valid) begin
                    state_next  = PRE;
                    crs_dv_next = 1'b1;
                    rxd_next    = 2'b01;
                end
            end
            PRE: begin
                crc_next      = '1;
                byte_cnt_next = '0;
                crs_dv_next   = 1'b1;
                rxd_next      = 2'b01;
                if (dcnt_reg == 16'd27) begin
                    state_next = SFD;
                    dcnt_next  = '0;
                end
            end
            SFD: begin
                crs_dv_next = 1'b1;
                rxd_next    = (dcnt_reg == 16'd2) ? 2'b11 : 2'b01;
            end
            DATA: begin
                crc_next    = crc_upd;
                crs_dv_next = 1'b1;
                rxd_next    = sh_next[1:0];
                if (dcnt_reg == 16'd3) begin
                    byte_cnt_next = byte_cnt_inc;
                    if (last_reg) begin
                        dcnt_next = '0;
                        if (byte_cnt_inc < MIN_BYTES) begin
                            state_next = PAD;
                            sh_next    = '0;
                            rxd_next   = 2'b00;
                        end else begin
                            state_next = FCS;
                            rxd_next   = ~crc_upd[1:0];
                        end
                    end
                end
            end
            PAD: begin
                crc_next    = crc_upd;
                crs_dv_next = 1'b1;
                if (dcnt_reg == 16'd3) begin
                    dcnt_next     = '0;
                    byte_cnt_next = byte_cnt_inc;
                    if (byte_cnt_inc >= MIN_BYTES) begin
                        state_next = FCS;
                        rxd_next   = ~crc_upd[1:0];
                    end
                end
            end
            FCS: begin
                crc_next    = {2'b00, crc_reg[31:2]};
                crs_dv_next = 1'b1;
                rxd_next    = ~crc_next[1:0];
                if (dcnt_reg == 16'd15) begin
                    state_next  = IPG;
                    dcnt_next   = '0;
                    crs_dv_next = 1'b0;
                    rxd_next    = 2'b00;
                end
            end
            IPG: begin
                // A pending frame leaves the gap directly so the gap is exactly IPG_DIBITS.
                if (dcnt_reg == IPG_LAST) begin
                    dcnt_next = '0;
                    if (tx_valid) begin
                        state_next  = PRE;
                        crs_dv_next = 1'b1;
                        rxd_next    = 2'b01;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (tx_ready) begin
            dcnt_next = '0;
            if (tx_valid) begin
                state_next  = DATA;
                sh_next     = tx_data;
                last_next   = tx_last;
                crs_dv_next = 1'b1;
                rxd_next    = tx_data[1:0];
            end else begin
                state_next    = IPG;
                underrun_next = 1'b1;
                crs_dv_next   = 1'b0;
                rxd_next      = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            dcnt_reg     <= '0;
            sh_reg       <= '0;
            last_reg     <= 1'b0;
            byte_cnt_reg <= '0;
            crc_reg      <= '1;
            rxd_reg      <= 2'b00;
            crs_dv_reg   <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            dcnt_reg     <= dcnt_next;
            sh_reg       <= sh_next;
            last_reg     <= last_next;
            byte_cnt_reg <= byte_cnt_next;
            crc_reg      <= crc_next;
            rxd_reg      <= rxd_next;
            crs_dv_reg   <= crs_dv_next;
            underrun_reg <= underrun_next;
        end
    end

endmodule

// File: tb/tb_ncsi_rbt_tx.sv
// Directed bench for ncsi_rbt_tx: a wire monitor collects frames and handshakes,
// and each scenario task compares them against hand-computed values and a CRC model.
module tb_ncsi_rbt_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00, tx0_data = 8'h00;
    logic       tx_valid = 1'b0, tx0_valid = 1'b0;
    logic       tx_last = 1'b0, tx0_last = 1'b0;
    logic       tx_ready, tx0_ready;
    logic [1:0] ncsi_rxd, rxd0;
    logic       ncsi_crs_dv, crs_dv0;
    logic       busy, busy0;
    logic       underrun, underrun0;

    ncsi_rbt_tx #(.IPG_DIBITS(48), .MIN_FRAME_BYTES(60)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .ncsi_rxd(ncsi_rxd), .ncsi_crs_dv(ncsi_crs_dv), .busy(busy),
        .underrun(underrun));

    ncsi_rbt_tx #(.IPG_DIBITS(48), .MIN_FRAME_BYTES(0)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx0_data), .tx_valid(tx0_valid), .tx_last(tx0_last),
        .tx_ready(tx0_ready), .ncsi_rxd(rxd0), .ncsi_crs_dv(crs_dv0), .busy(busy0),
        .underrun(underrun0));

    int n_checks = 0;
    int n_fails  = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor observes either instance, selected by sel0.
    bit sel0 = 1'b0;
    logic [1:0] m_rxd;
    logic m_crs, m_ready, m_under, m_busy;
    assign m_rxd   = sel0 ? rxd0 : ncsi_rxd;
    assign m_crs   = sel0 ? crs_dv0 : ncsi_crs_dv;
    assign m_ready = sel0 ? tx0_ready : tx_ready;
    assign m_under = sel0 ? underrun0 : underrun;
    assign m_busy  = sel0 ? busy0 : busy;

    logic [1:0] dib_q[$];
    int f_start[$], f_len[$], f_start_cyc[$], f_end_cyc[$], gap_q[$];
    int rdy_cyc[$], und_cyc[$], busy_fall[$];
    int cur_len = 0, low_run = 0;
    bit seen_frame = 1'b0;
    logic prev_crs = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (m_crs === 1'b1) begin
            if (prev_crs !== 1'b1) begin
                f_start.push_back(dib_q.size());
                f_start_cyc.push_back(cyc);
                if (seen_frame) gap_q.push_back(low_run);
                cur_len = 0;
            end
            dib_q.push_back(m_rxd);
            cur_len++;
        end else begin
            if (prev_crs === 1'b1) begin
                f_len.push_back(cur_len);
                f_end_cyc.push_back(cyc);
                seen_frame = 1'b1;
                low_run = 0;
            end
            low_run++;
        end
        if (m_ready === 1'b1) rdy_cyc.push_back(cyc);
        if (m_under === 1'b1) und_cyc.push_back(cyc);
        if (prev_busy === 1'b1 && m_busy === 1'b0) busy_fall.push_back(cyc);
        prev_crs  = m_crs;
        prev_busy = m_busy;
    end

    task automatic mon_clear();
        dib_q.delete(); f_start.delete(); f_len.delete(); f_start_cyc.delete();
        f_end_cyc.delete(); gap_q.delete(); rdy_cyc.delete(); und_cyc.delete();
        busy_fall.delete();
        seen_frame = 1'b0; low_run = 0; cur_len = 0;
    endtask

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'(seed + 13 * i);
    endfunction

    // Byte k of frame f, counted from the first preamble dibit.
    function automatic logic [7:0] mon_byte(input int f, input int k);
        int b;
        if (f >= f_start.size()) return 8'hxx;
        b = f_start[f] + 4 * k;
        if (b + 3 >= dib_q.size()) return 8'hxx;
        return {dib_q[b+3], dib_q[b+2], dib_q[b+1], dib_q[b]};
    endfunction

    function automatic int payload_errs(input int f, input int seed, input int n, input int total);
        int e;
        logic [7:0] exp_b;
        e = 0;
        for (int k = 0; k < total; k++) begin
            exp_b = (k < n) ? pat(seed, k) : 8'h00;
            if (mon_byte(f, 8 + k) !== exp_b) e++;
        end
        return e;
    endfunction

    function automatic int preamble_errs(input int f);
        int e;
        logic [1:0] exp_d;
        e = 0;
        for (int i = 0; i < 32; i++) begin
            exp_d = (i == 31) ? 2'b11 : 2'b01;
            if (f >= f_start.size() || f_start[f] + i >= dib_q.size()) e++;
            else if (dib_q[f_start[f] + i] !== exp_d) e++;
        end
        return e;
    endfunction

    function automatic logic [31:0] wire_fcs(input int f, input int nbytes);
        return {mon_byte(f, 8 + nbytes + 3), mon_byte(f, 8 + nbytes + 2),
                mon_byte(f, 8 + nbytes + 1), mon_byte(f, 8 + nbytes)};
    endfunction

    // Byte-wise reflected CRC-32 over payload plus zero pad, returned complemented.
    function automatic logic [31:0] fcs_model(input int seed, input int n, input int total);
        logic [31:0] c;
        logic [7:0] b;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < total; k++) begin
            b = (k < n) ? pat(seed, k) : 8'h00;
            c = c ^ {24'h0, b};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    logic [7:0] s_data[$];
    bit s_last[$];

    task automatic add_frame(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            s_data.push_back(pat(seed, i));
            s_last.push_back(i == n - 1);
        end
    endtask

    task automatic set_in(input bit to0, input logic v, input logic [7:0] d, input logic l);
        if (to0) begin
            tx0_valid = v; tx0_data = d; tx0_last = l;
        end else begin
            tx_valid = v; tx_data = d; tx_last = l;
        end
    endtask

    // Offers queued bytes continuously, advancing on each accepted handshake.
    task automatic drive_stream(input bit to0, input int budget);
        int idx, n;
        bit acc;
        idx = 0; n = 0;
        while (idx < s_data.size() && n < budget) begin
            set_in(to0, 1'b1, s_data[idx], s_last[idx]);
            @(negedge clk);
            acc = to0 ? tx0_ready : tx_ready;
            @(posedge clk); #1;
            n++;
            if (acc) idx++;
        end
        set_in(to0, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (idx != s_data.size()) begin
            n_fails++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", idx, s_data.size());
        end
        s_data.delete(); s_last.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_busy !== 1'b0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        n_checks++;
        if (m_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", m_busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ncsi_rxd !== 2'b00) begin n_fails++; $display("FAIL reset_rxd: got %b, required 00", ncsi_rxd); end
        n_checks++; if (ncsi_crs_dv !== 1'b0) begin n_fails++; $display("FAIL reset_crs_dv: got %b, required 0", ncsi_crs_dv); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fails++; $display("FAIL reset_tx_ready: got %b, required 0", tx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (underrun !== 1'b0) begin n_fails++; $display("FAIL reset_underrun: got %b, required 0", underrun); end
        n_checks++; if (busy0 !== 1'b0 || crs_dv0 !== 1'b0) begin n_fails++; $display("FAIL reset_dut0: busy=%b crs_dv=%b, required 0 0", busy0, crs_dv0); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ncsi_crs_dv !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL idle_after_reset: crs_dv=%b busy=%b, required 0 0", ncsi_crs_dv, busy); end
        mon_clear();
        $display("test_reset done");
    endtask

    task automatic test_preamble_and_padding();
        int t0;
        mon_clear();
        add_frame(1, 8'hAB);
        t0 = cyc;
        drive_stream(1'b0, 500);
        wait_idle(1000);
        n_checks++; if (f_len.size() != 1) begin n_fails++; $display("FAIL pad_frames: got %0d frames, required 1", f_len.size()); end
        if (f_len.size() >= 1) begin
            n_checks++; if (f_start_cyc[0] - t0 != 1) begin n_fails++; $display("FAIL crs_latency: got %0d clocks, required 1", f_start_cyc[0] - t0); end
            n_checks++; if (f_len[0] != 288) begin n_fails++; $display("FAIL pad_crs_len: got %0d, required 288", f_len[0]); end
            n_checks++; if (preamble_errs(0) != 0) begin n_fails++; $display("FAIL preamble_sfd: got %0d bad dibits, required 0", preamble_errs(0)); end
            n_checks++; if (rdy_cyc.size() != 1) begin n_fails++; $display("FAIL pad_ready_count: got %0d, required 1", rdy_cyc.size()); end
            else begin
                n_checks++; if (rdy_cyc[0] != f_start_cyc[0] + 31) begin n_fails++; $display("FAIL sfd_ready_pos: got crs cycle %0d, required 32", rdy_cyc[0] - f_start_cyc[0] + 1); end
            end
            n_checks++; if (payload_errs(0, 8'hAB, 1, 60) != 0) begin n_fails++; $display("FAIL pad_payload: got %0d bad bytes, required 0", payload_errs(0, 8'hAB, 1, 60)); end
            n_checks++; if (wire_fcs(0, 60) !== fcs_model(8'hAB, 1, 60)) begin n_fails++; $display("FAIL pad_fcs: got %h, required %h", wire_fcs(0, 60), fcs_model(8'hAB, 1, 60)); end
        end
        n_checks++; if (und_cyc.size() != 0) begin n_fails++; $display("FAIL pad_underrun: got %0d pulses, required 0", und_cyc.size()); end
        $display("test_preamble_and_padding done: crs_len=%0d", (f_len.size() > 0) ? f_len[0] : -1);
    endtask

    task automatic test_crc_vector();
        logic [7:0] v[9];
        logic [7:0] fcs_exp[4];
        v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fcs_exp = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        sel0 = 1'b1;
        mon_clear();
        for (int i = 0; i < 9; i++) begin
            s_data.push_back(v[i]);
            s_last.push_back(i == 8);
        end
        drive_stream(1'b1, 500);
        wait_idle(1000);
        n_checks++; if (f_len.size() != 1) begin n_fails++; $display("FAIL crc_frames: got %0d frames, required 1", f_len.size()); end
        else begin
            n_checks++; if (f_len[0] != 84) begin n_fails++; $display("FAIL crc_crs_len: got %0d, required 84", f_len[0]); end
            for (int i = 0; i < 9; i++) begin
                n_checks++; if (mon_byte(0, 8 + i) !== v[i]) begin n_fails++; $display("FAIL crc_payload[%0d]: got %h, required %h", i, mon_byte(0, 8 + i), v[i]); end
            end
            for (int j = 0; j < 4; j++) begin
                n_checks++; if (mon_byte(0, 17 + j) !== fcs_exp[j]) begin n_fails++; $display("FAIL crc_fcs[%0d]: got %h, required %h", j, mon_byte(0, 17 + j), fcs_exp[j]); end
            end
        end
        sel0 = 1'b0;
        mon_clear();
        $display("test_crc_vector done");
    endtask

    task automatic test_back_to_back();
        int bad;
        mon_clear();
        add_frame(64, 8'h10);
        add_frame(64, 8'h80);
        drive_stream(1'b0, 3000);
        wait_idle(2000);
        n_checks++; if (f_len.size() != 2) begin n_fails++; $display("FAIL b2b_frames: got %0d frames, required 2", f_len.size()); end
        else begin
            n_checks++; if (gap_q.size() != 1 || gap_q[0] != 48) begin n_fails++; $display("FAIL b2b_gap: got %0d, required 48", (gap_q.size() > 0) ? gap_q[0] : -1); end
            for (int f = 0; f < 2; f++) begin
                n_checks++; if (f_len[f] != 304) begin n_fails++; $display("FAIL b2b_len[%0d]: got %0d, required 304", f, f_len[f]); end
                n_checks++; if (payload_errs(f, (f == 0) ? 8'h10 : 8'h80, 64, 64) != 0) begin n_fails++; $display("FAIL b2b_payload[%0d]: got %0d bad bytes, required 0", f, payload_errs(f, (f == 0) ? 8'h10 : 8'h80, 64, 64)); end
                n_checks++; if (wire_fcs(f, 64) !== fcs_model((f == 0) ? 8'h10 : 8'h80, 64, 64)) begin n_fails++; $display("FAIL b2b_fcs[%0d]: got %h, required %h", f, wire_fcs(f, 64), fcs_model((f == 0) ? 8'h10 : 8'h80, 64, 64)); end
            end
            n_checks++; if (rdy_cyc.size() != 128) begin n_fails++; $display("FAIL b2b_ready_count: got %0d, required 128", rdy_cyc.size()); end
            else begin
                bad = 0;
                for (int i = 0; i < 128; i++) begin
                    if (i % 64 == 0) begin
                        if (rdy_cyc[i] != f_start_cyc[i / 64] + 31) bad++;
                    end else if (rdy_cyc[i] - rdy_cyc[i-1] != 4) bad++;
                end
                n_checks++; if (bad != 0) begin n_fails++; $display("FAIL b2b_ready_spacing: got %0d misplaced pulses, required 0", bad); end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_underrun();
        mon_clear();
        for (int i = 0; i < 9; i++) begin
            s_data.push_back(pat(8'h21, i));
            s_last.push_back(1'b0);
        end
        drive_stream(1'b0, 500);
        wait_idle(1000);
        n_checks++; if (und_cyc.size() != 1) begin n_fails++; $display("FAIL und_pulses: got %0d, required 1", und_cyc.size()); end
        n_checks++; if (f_len.size() != 1 || rdy_cyc.size() != 10) begin n_fails++; $display("FAIL und_shape: got %0d frames %0d ready pulses, required 1 10", f_len.size(), rdy_cyc.size()); end
        else begin
            n_checks++; if (f_len[0] != 68) begin n_fails++; $display("FAIL und_crs_len: got %0d, required 68", f_len[0]); end
            n_checks++; if (f_end_cyc[0] != rdy_cyc[9] + 1) begin n_fails++; $display("FAIL und_crs_drop: got %0d clocks after load point, required 1", f_end_cyc[0] - rdy_cyc[9]); end
            if (und_cyc.size() == 1) begin
                n_checks++; if (und_cyc[0] != f_end_cyc[0]) begin n_fails++; $display("FAIL und_pulse_pos: got cycle %0d, required %0d", und_cyc[0], f_end_cyc[0]); end
            end
            n_checks++; if (busy_fall.size() != 1 || busy_fall[0] != f_end_cyc[0] + 48) begin n_fails++; $display("FAIL und_ipg: got busy fall %0d clocks after crs drop, required 48", (busy_fall.size() > 0) ? busy_fall[0] - f_end_cyc[0] : -1); end
            n_checks++; if (payload_errs(0, 8'h21, 9, 9) != 0) begin n_fails++; $display("FAIL und_payload: got %0d bad bytes, required 0", payload_errs(0, 8'h21, 9, 9)); end
        end
        mon_clear();
        add_frame(60, 8'h33);
        drive_stream(1'b0, 1000);
        wait_idle(1000);
        n_checks++; if (f_len.size() != 1 || f_len[0] != 288) begin n_fails++; $display("FAIL und_next_len: got %0d, required 288", (f_len.size() > 0) ? f_len[0] : -1); end
        n_checks++; if (payload_errs(0, 8'h33, 60, 60) != 0) begin n_fails++; $display("FAIL und_next_payload: got %0d bad bytes, required 0", payload_errs(0, 8'h33, 60, 60)); end
        n_checks++; if (wire_fcs(0, 60) !== fcs_model(8'h33, 60, 60)) begin n_fails++; $display("FAIL und_next_fcs: got %h, required %h", wire_fcs(0, 60), fcs_model(8'h33, 60, 60)); end
        $display("test_underrun done");
    endtask

    task automatic test_reset_mid_fcs();
        int n;
        mon_clear();
        add_frame(60, 8'h5A);
        drive_stream(1'b0, 1000);
        n = 0;
        while (cur_len < 278 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        n_checks++; if (ncsi_crs_dv !== 1'b1 || busy !== 1'b1) begin n_fails++; $display("FAIL pre_reset_in_fcs: crs_dv=%b busy=%b len=%0d, required 1 1", ncsi_crs_dv, busy, cur_len); end
        reset = 1'b1;
        #1;
        n_checks++; if (ncsi_rxd !== 2'b00) begin n_fails++; $display("FAIL async_rxd: got %b, required 00", ncsi_rxd); end
        n_checks++; if (ncsi_crs_dv !== 1'b0) begin n_fails++; $display("FAIL async_crs_dv: got %b, required 0", ncsi_crs_dv); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL async_busy: got %b, required 0", busy); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fails++; $display("FAIL async_tx_ready: got %b, required 0", tx_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || ncsi_crs_dv !== 1'b0) begin n_fails++; $display("FAIL post_reset_idle: busy=%b crs_dv=%b, required 0 0", busy, ncsi_crs_dv); end
        mon_clear();
        add_frame(60, 8'h77);
        drive_stream(1'b0, 1000);
        wait_idle(1000);
        n_checks++; if (f_len.size() != 1 || f_len[0] != 288) begin n_fails++; $display("FAIL rst_next_len: got %0d, required 288", (f_len.size() > 0) ? f_len[0] : -1); end
        n_checks++; if (preamble_errs(0) != 0) begin n_fails++; $display("FAIL rst_next_preamble: got %0d bad dibits, required 0", preamble_errs(0)); end
        n_checks++; if (payload_errs(0, 8'h77, 60, 60) != 0) begin n_fails++; $display("FAIL rst_next_payload: got %0d bad bytes, required 0", payload_errs(0, 8'h77, 60, 60)); end
        n_checks++; if (wire_fcs(0, 60) !== fcs_model(8'h77, 60, 60)) begin n_fails++; $display("FAIL rst_next_fcs: got %h, required %h", wire_fcs(0, 60), fcs_model(8'h77, 60, 60)); end
        $display("test_reset_mid_fcs done");
    endtask

    initial begin
        test_reset();
        test_preamble_and_padding();
        test_crc_vector();
        test_back_to_back();
        test_underrun();
        test_reset_mid_fcs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
